bram_fifo_256x16: RTL
=====================

# bram_fifo_256x16

Single-clock, first-word-fall-through FIFO, 256 deep × 16 bits, built on one `dram_256x16` block-RAM instance, with valid/ready handshakes on both sides. The FIFO sits directly upstream of consumers of buffered streams: it owns the BRAM write/read pointers, issues BRAM reads, and hides the BRAM's one-cycle registered read latency behind a 2-entry output stage. Sustained throughput is one word per cycle in each direction.

## Interface
- `AF_THRESH`, 240: `almost_full` asserts when `count >= AF_THRESH`.
- `AE_THRESH`, 16: `almost_empty` asserts when `count <= AE_THRESH`.

Ports:
- `clk`  in  1  sole clock; drives both BRAM ports.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear.
- `in_data`  in  16  write word.
- `in_valid`  in  1  write request.
- `in_ready`  out  1  FIFO can accept.
- `out_data`  out  16  head word.
- `out_valid`  out  1  head word valid.
- `out_ready`  in  1  consumer takes head.
- `count`  out  9  words held, 0..256.
- `almost_full`, `almost_empty`  out  1  threshold flags.

## Operation
- Push occurs on an edge where `in_valid & in_ready`. Pop occurs on an edge where `out_valid & out_ready`.
- `count` is 9 bits. It increments on a push, decrements on a pop, and is unchanged when both occur. It covers words in the BRAM, in-flight reads and the output stage.
- `in_ready = (count != 256) & ~flush`. It does not depend on `out_ready`: at full, a simultaneous pop does not enable a push in the same cycle.
- Pointers: `wptr` and `rptr` are 8 bits and wrap 255 → 0 naturally. `bram_cnt = wptr_ext − rptr_ext` uses 9-bit extended pointers.
- A push writes `in_data` to address `wptr`, with BRAM `we=1` and `mask=0`. `wptr` then increments.
- A read is issued (`re=1`, `raddr=rptr`, then `rptr++`) when both hold:
  - `bram_cnt != 0`, computed from registered pointers only, so the word written this edge is never read in the same cycle.
  - Output-stage occupancy after this cycle's pop, plus reads in flight, is less than 2.
- In-flight tracking: a 1-bit `rd_pend` register. Data in `q` is captured into the output stage on the edge after `rd_pend`.
- Output stage: a 2-entry FIFO of registers. `out_data` is always entry 0; `out_valid` is 1 when occupancy is at least 1.
- Flush is applied on the edge where `flush=1`. It:
  - zeroes `wptr`, `rptr`, `rd_pend`, stage occupancy and `count`;
  - discards any BRAM read in flight;
  - ignores any push or pop in that cycle.
- There is no bypass path. An empty FIFO never forwards `in_data` combinationally.

## Timing
- Reset values (asynchronous on `rst_n` low, including mid-transfer): `count=0`, `out_valid=0`, `out_data=0`, `almost_empty=1`, `almost_full=0`, `in_ready=1`, pointers=0, `rd_pend=0`. BRAM contents are not cleared.
- Latency, empty FIFO:
  - push on edge k → read issued in cycle k..k+1;
  - BRAM `q` valid after edge k+1;
  - `out_valid=1` with data after edge k+2.
- Latency, non-empty FIFO: the stage stays primed, and back-to-back pops with `out_ready=1` continuously yield one word per cycle.
- Flags are combinational from registered `count` and update on the same edge as `count`.
- Full (256): `in_ready=0` until the first pop edge; it returns to 1 in the next cycle.
- Empty: `out_valid=0`, and `out_ready` is ignored.

## Structure
- Package `fifo_pkg`: `FIFO_DEPTH=256`, `FIFO_DW=16`, `FIFO_AW=8`, `FIFO_CW=9`.
- Sub-module `fifo_out_stage`: the 2-entry register FIFO with load and pop, reporting its occupancy.
- Top level contains:
  - the pointers, `count` and read-issue logic;
  - one `dram_256x16` with `w_clk=r_clk=clk` and both clock enables tied to 1.

## Test plan
- Reset: drive `rst_n=0` mid-stream → all outputs at reset values; the first push after release of 0x0001 appears with `out_valid=1` two edges after its push edge.
- Latency: push 0xA5A5 at edge k into an empty FIFO, with `out_ready=0` → `out_valid` rises after edge k+2, `out_data=0xA5A5`, `count=1`.
- Fill:
  - push 0..255 with `out_ready=0` → `almost_full` rises when `count=240`, `in_ready=0` at `count=256`;
  - present word 256 → it is held, not written;
  - pop all → data 0..255 in order, `almost_empty` returns at `count=16`.
- Full with simultaneous pop: at `count=256`, assert `out_ready=1` and `in_valid=1` → `count=255` and `in_ready=0` that cycle; the push is accepted the next cycle and `count` returns to 256.
- Streaming across wrap: 1000 incrementing words, random `in_valid`/`out_ready` (50%) → output in order with no loss or duplication, `count` matching the scoreboard every cycle.
- Flush with read in flight: pulse `flush` one cycle after a read issue → next cycle `count=0` and `out_valid=0`; a following push of 0x1234 is the first word out.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the 256x16 block-RAM FIFO and its output stage.
package fifo_pkg;
    localparam int FIFO_DEPTH = 256;
    localparam int FIFO_DW    = 16;
    localparam int FIFO_AW    = 8;
    localparam int FIFO_CW    = 9;
endpackage

// File: rtl/dram_256x16.sv
// Dual-port 256x16 block RAM: masked synchronous write, registered (1-cycle) read.
module dram_256x16 (
    input  logic        w_clk,
    input  logic        w_ce,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [15:0] mask,
    input  logic        r_clk,
    input  logic        r_ce,
    input  logic        re,
    input  logic [7:0]  raddr,
    output logic [15:0] q
);
    logic [15:0] mem [256];

    // A set mask bit protects that bit of the stored word.
    always_ff @(posedge w_clk) begin
        if (w_ce && we) begin
            mem[waddr] <= (mem[waddr] & mask) | (wdata & ~mask);
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_ce && re) begin
            q <= mem[raddr];
        end
    end
endmodule

// File: rtl/fifo_out_stage.sv
// Two-entry register FIFO holding words already read from the BRAM; head is entry 0.
module fifo_out_stage
    import fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [FIFO_DW-1:0] load_data,
    input  logic               pop,
    output logic [FIFO_DW-1:0] head,
    output logic [1:0]         occ
);
    logic [FIFO_DW-1:0] entry0;
    logic [FIFO_DW-1:0] entry1;

    assign head = entry0;

    // The read-issue logic upstream guarantees no load into a full stage
    // and no pop from an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= 2'd0;
        end else if (clear) begin
            occ <= 2'd0;
        end else begin
            case ({load, pop})
                2'b11: begin
                    if (occ == 2'd1) begin
                        entry0 <= load_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= load_data;
                    end
                end
                2'b10: begin
                    if (occ == 2'd0) entry0 <= load_data;
                    else             entry1 <= load_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bram_fifo_256x16.sv
// First-word-fall-through 256x16 FIFO on one dram_256x16, with a 2-entry output
// stage hiding the BRAM read latency so both sides sustain one word per cycle.
module bram_fifo_256x16
    import fifo_pkg::*;
#(
    parameter int AF_THRESH = 240,
    parameter int AE_THRESH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [FIFO_DW-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FIFO_DW-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_CW-1:0] count,
    output logic               almost_full,
    output logic               almost_empty
);
    localparam logic [FIFO_CW-1:0] AF_LIM = FIFO_CW'(AF_THRESH);
    localparam logic [FIFO_CW-1:0] AE_LIM = FIFO_CW'(AE_THRESH);
    localparam logic [FIFO_CW-1:0] FULL   = FIFO_CW'(FIFO_DEPTH);

    logic [FIFO_CW-1:0] wptr_ext, rptr_ext, bram_cnt, count_q;
    logic               rd_pend;
    logic [1:0]         occ, occ_after_pop;
    logic               push, pop, issue;
    logic [FIFO_DW-1:0] q;

    // Handshake: a word moves on an edge where valid & ready are both high;
    // valid never waits on ready, and in_ready ignores out_ready so a pop at
    // full frees space only from the following cycle.
    assign in_ready     = (count_q != FULL) & ~flush;
    assign push         = in_valid & in_ready;
    assign out_valid    = (occ != 2'd0);
    assign pop          = out_valid & out_ready & ~flush;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LIM);
    assign almost_empty = (count_q <= AE_LIM);

    // Registered pointers only: a word written this edge is not yet readable.
    assign bram_cnt      = wptr_ext - rptr_ext;
    assign occ_after_pop = occ - {1'b0, pop};
    assign issue         = ~flush & (bram_cnt != '0) & ((occ_after_pop + {1'b0, rd_pend}) < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_ext <= '0;
            rptr_ext <= '0;
            rd_pend  <= 1'b0;
            count_q  <= '0;
        end else if (flush) begin
            wptr_ext <= '0;
            rptr_ext <= '0;
            rd_pend  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push)  wptr_ext <= wptr_ext + 1'b1;
            if (issue) rptr_ext <= rptr_ext + 1'b1;
            rd_pend <= issue;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    dram_256x16 u_dram (
        .w_clk (clk),
        .w_ce  (1'b1),
        .we    (push),
        .waddr (wptr_ext[FIFO_AW-1:0]),
        .wdata (in_data),
        .mask  ('0),
        .r_clk (clk),
        .r_ce  (1'b1),
        .re    (issue),
        .raddr (rptr_ext[FIFO_AW-1:0]),
        .q     (q)
    );

    fifo_out_stage u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .load      (rd_pend & ~flush),
        .load_data (q),
        .pop       (pop),
        .head      (out_data),
        .occ       (occ)
    );
endmodule
